// File: rtl/vedic_seq_pkg.sv
// Shared types and constants for the sequential 8x8 Vedic multiplier.
// Define VEDIC_SEQ_MAC_EN for the 20-bit multiply-accumulate build.
package vedic_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    localparam int STEP_W = 2;

    localparam logic [3:0] SH_0 = 4'd0;
    localparam logic [3:0] SH_1 = 4'd4;
    localparam logic [3:0] SH_2 = 4'd4;
    localparam logic [3:0] SH_3 = 4'd8;

`ifdef VEDIC_SEQ_MAC_EN
    localparam int RES_W = 20;
`else
    localparam int RES_W = 16;
`endif

    function automatic logic [3:0] step_shift(
        input logic [STEP_W-1:0] s
    );
        logic [3:0] sh;
        unique case (s)
            2'd0:    sh = SH_0;
            2'd1:    sh = SH_1;
            2'd2:    sh = SH_2;
            default: sh = SH_3;
        endcase
        return sh;
    endfunction

    // Urdhva-tiryak 2x2: vertical terms at the ends, crosswise pair in the middle
    function automatic logic [3:0] vedic2x2(
        input logic [1:0] x,
        input logic [1:0] y
    );
        logic c1;
        logic d1;
        logic hh;
        logic cy;
        c1 = x[1] & y[0];
        d1 = x[0] & y[1];
        hh = x[1] & y[1];
        cy = c1 & d1;
        return {hh & cy, hh ^ cy, c1 ^ d1, x[0] & y[0]};
    endfunction

endpackage

// File: rtl/vedic_mul4x4.sv
// Combinational 4x4 Vedic multiplier built from four 2x2 blocks.
// Used unchanged in both the plain and VEDIC_SEQ_MAC_EN builds.
module vedic_mul4x4
    import vedic_seq_pkg::*;
(
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [7:0] p
);

    logic [3:0] q0;
    logic [3:0] q1;
    logic [3:0] q2;
    logic [3:0] q3;
    logic [5:0] mid;

    assign q0 = vedic2x2(x[1:0], y[1:0]);
    assign q1 = vedic2x2(x[3:2], y[1:0]);
    assign q2 = vedic2x2(x[1:0], y[3:2]);
    assign q3 = vedic2x2(x[3:2], y[3:2]);

    // Everything from bit 2 upward, aligned at weight 4
    assign mid = {2'b00, q1} + {2'b00, q2} + {4'b0000, q0[3:2]};

    assign p[1:0] = q0[1:0];
    assign p[7:2] = mid + {q3, 2'b00};

endmodule

// File: rtl/vedic_8x8_seq.sv
// 8x8 unsigned multiplier reusing one 4x4 Vedic core over four cycles.
// VEDIC_SEQ_MAC_EN widens the result to 20 bits and adds acc_clr (MAC mode).
module vedic_8x8_seq
    import vedic_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef VEDIC_SEQ_MAC_EN
    input  logic             acc_clr,
`endif
    output logic [RES_W-1:0] product
);

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        a_q;
    logic [7:0]        b_q;
    logic [STEP_W-1:0] step;
    logic [RES_W-1:0]  acc;
    logic [RES_W-1:0]  acc_base;
    logic [RES_W-1:0]  pp_sh;
    logic [3:0]        x_nib;
    logic [3:0]        y_nib;
    logic [7:0]        pp;
    logic              accept;
    logic              fire;

    assign accept = in_valid && in_ready;
    assign fire   = out_valid && out_ready;

    // step[0] picks the a nibble, step[1] the b nibble
    assign x_nib = step[0] ? a_q[7:4] : a_q[3:0];
    assign y_nib = step[1] ? b_q[7:4] : b_q[3:0];

    vedic_mul4x4 u_core (
        .x (x_nib),
        .y (y_nib),
        .p (pp)
    );

    assign pp_sh = RES_W'(pp) << step_shift(step);

`ifdef VEDIC_SEQ_MAC_EN
    assign acc_base = acc_clr ? '0 : acc;
`else
    assign acc_base = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = MUL;
            MUL:     if (step == STEP_W'(3)) state_nxt = DONE;
            DONE:    if (fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        product   = acc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q  <= '0;
            b_q  <= '0;
            step <= '0;
            acc  <= '0;
        end else if (accept) begin
            a_q  <= a;
            b_q  <= b;
            step <= '0;
            acc  <= acc_base;
        end else if (state == MUL) begin
            step <= step + STEP_W'(1);
            acc  <= acc + pp_sh;
        end
    end

endmodule

// File: tb/tb_vedic_8x8_seq.sv
// Scoreboard bench for vedic_8x8_seq: directed vectors, queue-based monitor.
// MAC checks compile in when VEDIC_SEQ_MAC_EN is defined.
module tb_vedic_8x8_seq;
    import vedic_seq_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b1;
    logic [7:0]       a = '0;
    logic [7:0]       b = '0;
    logic             in_ready;
    logic             out_valid;
    logic [RES_W-1:0] product;
`ifdef VEDIC_SEQ_MAC_EN
    logic             acc_clr = 1'b1;
`endif

    int checks = 0;
    int passes = 0;
    logic [RES_W-1:0] exp_q[$];

    vedic_8x8_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef VEDIC_SEQ_MAC_EN
        .acc_clr   (acc_clr),
`endif
        .product   (product)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] expv);
        checks++;
        if (got === expv) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, got, expv);
    endtask

    // Monitor: samples mid-low-phase, pops on every handshake
    always begin
        @(negedge clk);
        #2;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_result: got %0d expected none",
                         product);
            end else begin
                chk("product", 32'(product), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic issue(input logic [7:0] x, input logic [7:0] y,
                         input logic [RES_W-1:0] e);
        int budget = 0;
        @(negedge clk);
        a = x;
        b = y;
        in_valid = 1'b1;
        while (!in_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) begin
            checks++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1");
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = 8'hAA;
        b = 8'h55;
    endtask

    task automatic wait_idle();
        int budget = 0;
        @(negedge clk);
        while (!in_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) begin
            checks++;
            $display("FAIL idle_timeout: got in_ready=0 expected 1");
        end
    endtask

    task automatic wait_valid();
        int budget = 0;
        while (!out_valid && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (!out_valid) begin
            checks++;
            $display("FAIL valid_timeout: got out_valid=0 expected 1");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int last;
        int nacc;
        logic [RES_W-1:0] e;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_product", 32'(product), 0);
        rst = 1'b0;

        // Basic with latency
        issue(8'd3, 8'd2, 6);
        repeat (3) @(negedge clk);
        chk("lat_not_yet", 32'(out_valid), 0);
        @(negedge clk);
        chk("lat_valid", 32'(out_valid), 1);
        wait_idle();
        issue(8'd5, 8'd4, 20);
        wait_idle();

        // Extremes
        issue(8'd255, 8'd255, 65025);
        wait_idle();
        issue(8'd9, 8'd0, 0);
        wait_idle();
        issue(8'hF0, 8'h0F, 3600);
        wait_idle();

        // Reset mid-MUL discards the partial result
        @(negedge clk);
        a = 8'd200;
        b = 8'd3;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("mul_busy", 32'(in_ready), 0);
        rst = 1'b1;
        #1;
        chk("abort_out_valid", 32'(out_valid), 0);
        chk("abort_in_ready", 32'(in_ready), 1);
        chk("abort_product", 32'(product), 0);
        repeat (3) @(negedge clk);
        chk("abort_hold_product", 32'(product), 0);
        rst = 1'b0;
        issue(8'd12, 8'd11, 132);
        wait_idle();

        // Backpressure
        out_ready = 1'b0;
        issue(8'd7, 8'd9, 63);
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = i[0];
            a = 8'd1;
            b = 8'd1;
            chk("bp_product", 32'(product), 63);
            chk("bp_out_valid", 32'(out_valid), 1);
            chk("bp_in_ready", 32'(in_ready), 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        #3;
        chk("bp_after_valid", 32'(out_valid), 0);
        chk("bp_after_ready", 32'(in_ready), 1);

        // Back-to-back with operands changing every cycle
        wait_idle();
        last = -1;
        nacc = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            a = 8'(c * 37 + 11);
            b = 8'(c * 53 + 7);
            in_valid = 1'b1;
            if (in_ready) begin
                exp_q.push_back(RES_W'(a) * RES_W'(b));
                if (last >= 0) chk("accept_interval", 32'(c - last), 6);
                last = c;
                nacc++;
            end
        end
        in_valid = 1'b0;
        chk("b2b_accepts", 32'(nacc), 5);
        wait_idle();

`ifdef VEDIC_SEQ_MAC_EN
        // Multiply-accumulate with wrap modulo 2^20
        acc_clr = 1'b1;
        issue(8'd255, 8'd255, 65025);
        wait_idle();
        acc_clr = 1'b0;
        issue(8'd255, 8'd255, 130050);
        wait_idle();
        for (int k = 3; k <= 19; k++) begin
            e = (k == 19) ? 20'd186899 : RES_W'(k * 65025);
            issue(8'd255, 8'd255, e);
            wait_idle();
        end
        acc_clr = 1'b1;
        issue(8'd2, 8'd3, 6);
        wait_idle();
`endif

        repeat (10) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
